// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

  // Access size lives in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] lane);
    logic r_mis;
    case (funct3[1:0])
      2'b01:   r_mis = lane[0];
      2'b10:   r_mis = |lane[1:0];
      2'b11:   r_mis = |lane;
      default: r_mis = 1'b0;
    endcase
    return r_mis;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    return we ? funct3[2] : (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and Datamemory bus bundle for the load/store unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_datain;
  logic              mem_w;
  logic              mem_r;
  logic [DATA_W-1:0] mem_dataout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataout,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_adr, mem_datain, mem_w, mem_r
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataout,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_adr, mem_datain, mem_w, mem_r
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Lane steering for the load/store unit: load extraction with sign/zero
// extension, and the store merge used by read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_lane,
  input  logic [2:0]        i_funct3,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_merged
);

  logic [5:0]        w_shamt;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mask;

  assign w_shamt = {i_lane, 3'b000};

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shifted = i_word >> w_shamt;
    case (i_funct3)
      F3_B:    o_rdata = {{(DATA_W-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    o_rdata = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_rdata = {{(DATA_W-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_D:    o_rdata = i_word;
      F3_BU:   o_rdata = {{(DATA_W-8){1'b0}},  w_shifted[7:0]};
      F3_HU:   o_rdata = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
      F3_WU:   o_rdata = {{(DATA_W-32){1'b0}}, w_shifted[31:0]};
      default: o_rdata = {DATA_W{1'b0}};
    endcase
  end

  // Store path: replace only the addressed lanes of the old doubleword.
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   w_mask = {{(DATA_W-8){1'b0}},  8'hFF};
      2'b01:   w_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      2'b10:   w_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: w_mask = {DATA_W{1'b1}};
    endcase
    o_merged = (i_word & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage controller: turns byte-addressed B/H/W/D requests into
// doubleword Datamemory accesses, with read-modify-write for narrow stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  lsu_state_t        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [2:0]        r_lane;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_datain;
  logic              r_mem_w;
  logic              r_mem_r;

  logic              w_err;
  logic [ADDR_W-1:0] w_index;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

  assign w_err   = is_illegal(bus.req_we, bus.req_funct3) ||
                   is_misaligned(bus.req_funct3, bus.req_addr[2:0]);
  assign w_index = {3'b000, bus.req_addr[ADDR_W-1:3]};

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_word   (bus.mem_dataout),
    .i_wdata  (r_wdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_rdata  (w_load),
    .o_merged (w_merged)
  );

  // Request FSM; every output is set on the edge that enters its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_lane       <= 3'b000;
      r_wdata      <= {DATA_W{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
      r_mem_adr    <= {ADDR_W{1'b0}};
      r_mem_datain <= {DATA_W{1'b0}};
      r_mem_w      <= 1'b0;
      r_mem_r      <= 1'b0;
    end else begin
      r_mem_r      <= 1'b0;
      r_mem_w      <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_lane   <= bus.req_addr[2:0];
            r_wdata  <= bus.req_wdata;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= {DATA_W{1'b0}};
            end else if (bus.req_we && (bus.req_funct3 == F3_D)) begin
              r_state      <= WR;
              r_mem_w      <= 1'b1;
              r_mem_adr    <= w_index;
              r_mem_datain <= bus.req_wdata;
            end else begin
              r_state   <= RD;
              r_mem_r   <= 1'b1;
              r_mem_adr <= w_index;
            end
          end
        end
        RD: r_state <= CAP;
        CAP: begin
          if (r_we) begin
            r_state      <= WR;
            r_mem_w      <= 1'b1;
            r_mem_datain <= w_merged;
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load;
          end
        end
        WR: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= {DATA_W{1'b0}};
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_adr    = r_mem_adr;
  assign bus.mem_datain = r_mem_datain;
  assign bus.mem_w      = r_mem_w;
  assign bus.mem_r      = r_mem_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small doubleword memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cyc = 0;

  logic [63:0] mem   [0:15];
  logic [63:0] model [0:15];

  logic [63:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  logic        exp_mw_q[$];
  logic [63:0] exp_madr_q[$];
  logic [63:0] exp_mdat_q[$];

  load_store_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datamemory model: write on mem_w, read data valid the following cycle.
  always @(posedge clk) begin
    if (bus.mem_w) mem[bus.mem_adr[3:0]] <= bus.mem_datain;
    if (bus.mem_r) bus.mem_dataout <= mem[bus.mem_adr[3:0]];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [63:0] a);
    int n;
    n = size_bytes(f3);
    if (we && f3[2]) return 1'b1;
    if (!we && f3 == 3'b111) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] w;
    logic [63:0] r;
    logic        sgn;
    int          n;
    w = model[a[6:3]];
    r = 64'd0;
    n = size_bytes(f3);
    for (int i = 0; i < 8; i++)
      if (i < n) r[8*i +: 8] = w[8*((a[2:0] + i) % 8) +: 8];
    sgn = (!f3[2] && n < 8) ? r[8*n-1] : 1'b0;
    for (int i = 0; i < 8; i++)
      if (i >= n) r[8*i +: 8] = {8{sgn}};
    return r;
  endfunction

  function automatic logic [63:0] ref_merge(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] wd);
    logic [63:0] w;
    int          n;
    w = model[a[6:3]];
    n = size_bytes(f3);
    for (int i = 0; i < 8; i++)
      if (i < n) w[8*((a[2:0] + i) % 8) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  // Output monitor: pops scoreboard entries as memory strobes and responses appear.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_r || bus.mem_w) begin
        check_eq("rw_excl", {63'd0, bus.mem_r & bus.mem_w}, 64'd0);
        if (exp_mw_q.size() == 0) begin
          check_eq("spur_mem", {62'd0, bus.mem_r, bus.mem_w}, 64'd0);
        end else begin
          logic        ew;
          logic [63:0] ea;
          logic [63:0] ed;
          ew = exp_mw_q.pop_front();
          ea = exp_madr_q.pop_front();
          ed = exp_mdat_q.pop_front();
          check_eq("mem_w_kind", {63'd0, bus.mem_w}, {63'd0, ew});
          check_eq("mem_adr", bus.mem_adr, ea);
          if (ew) check_eq("mem_datain", bus.mem_datain, ed);
        end
      end
      if (bus.resp_valid) begin
        if (exp_err_q.size() == 0) begin
          check_eq("spur_resp", {63'd0, bus.resp_valid}, 64'd0);
        end else begin
          logic        ee;
          logic [63:0] er;
          int          el;
          ee = exp_err_q.pop_front();
          er = exp_rdata_q.pop_front();
          el = exp_lat_q.pop_front();
          check_eq("resp_err", {63'd0, bus.resp_err}, {63'd0, ee});
          check_eq("resp_rdata", bus.resp_rdata, er);
          check_eq("latency", 64'(cyc - acc_cyc + 1), 64'(el));
        end
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd);
    int k;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) check_eq("ready_timeout", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && (exp_err_q.size() + exp_mw_q.size()) != 0; i++) @(posedge clk);
    if ((exp_err_q.size() + exp_mw_q.size()) != 0) begin
      check_eq("resp_timeout", 64'(exp_err_q.size() + exp_mw_q.size()), 64'd0);
      exp_err_q.delete(); exp_rdata_q.delete(); exp_lat_q.delete();
      exp_mw_q.delete(); exp_madr_q.delete(); exp_mdat_q.delete();
    end
  endtask

  task automatic push_mem(input logic w, input logic [63:0] a, input logic [63:0] d);
    exp_mw_q.push_back(w);
    exp_madr_q.push_back({3'b000, a[63:3]});
    exp_mdat_q.push_back(d);
  endtask

  // One full transaction; use_lit replaces the model's load result with a fixed value.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input bit use_lit, input logic [63:0] lit);
    logic        e;
    logic [63:0] merged;
    e = ref_err(we, f3, a);
    exp_err_q.push_back(e);
    if (e) begin
      exp_rdata_q.push_back(64'd0);
      exp_lat_q.push_back(1);
    end else if (we && f3 == 3'b011) begin
      push_mem(1'b1, a, wd);
      model[a[6:3]] = wd;
      exp_rdata_q.push_back(64'd0);
      exp_lat_q.push_back(2);
    end else if (we) begin
      merged = ref_merge(f3, a, wd);
      push_mem(1'b0, a, 64'd0);
      push_mem(1'b1, a, merged);
      model[a[6:3]] = merged;
      exp_rdata_q.push_back(64'd0);
      exp_lat_q.push_back(4);
    end else begin
      push_mem(1'b0, a, 64'd0);
      exp_rdata_q.push_back(use_lit ? lit : ref_load(f3, a));
      exp_lat_q.push_back(3);
    end
    send(we, f3, a, wd);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},  {63'd0, bus.req_ready}, 64'd1);
    check_eq({tag, "_rvalid"}, {63'd0, bus.resp_valid}, 64'd0);
    check_eq({tag, "_rerr"},   {63'd0, bus.resp_err}, 64'd0);
    check_eq({tag, "_rdata"},  bus.resp_rdata, 64'd0);
    check_eq({tag, "_memrw"},  {62'd0, bus.mem_r, bus.mem_w}, 64'd0);
    check_eq({tag, "_madr"},   bus.mem_adr, 64'd0);
    check_eq({tag, "_mdin"},   bus.mem_datain, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 64'd0;
      model[i] = 64'd0;
    end
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_funct3  = 3'b000;
    bus.req_addr    = 64'd0;
    bus.req_wdata   = 64'd0;
    bus.mem_dataout = 64'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    do_req(1'b1, 3'b011, 64'd8,  64'h8877_6655_4433_2211, 1'b0, 64'd0);
    do_req(1'b0, 3'b000, 64'd15, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88);
    do_req(1'b0, 3'b100, 64'd15, 64'd0, 1'b1, 64'h0000_0000_0000_0088);
    do_req(1'b0, 3'b001, 64'd10, 64'd0, 1'b1, 64'h0000_0000_0000_4433);
    do_req(1'b0, 3'b010, 64'd12, 64'd0, 1'b1, 64'hFFFF_FFFF_8877_6655);
    do_req(1'b0, 3'b110, 64'd12, 64'd0, 1'b1, 64'h0000_0000_8877_6655);
    do_req(1'b1, 3'b000, 64'd9,  64'h0000_0000_0000_00AB, 1'b0, 64'd0);
    do_req(1'b0, 3'b011, 64'd8,  64'd0, 1'b1, 64'h8877_6655_4433_AB11);
    do_req(1'b0, 3'b010, 64'd6,  64'd0, 1'b0, 64'd0);
    do_req(1'b0, 3'b111, 64'd0,  64'd0, 1'b0, 64'd0);
    do_req(1'b1, 3'b100, 64'd0,  64'h55, 1'b0, 64'd0);
    do_req(1'b1, 3'b011, 64'd20, 64'h1234, 1'b0, 64'd0);

    // Abort a sub-word store with reset while it sits in CAP.
    do_req(1'b1, 3'b011, 64'd16, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0);
    push_mem(1'b0, 64'd16, 64'd0);
    send(1'b1, 3'b010, 64'd16, 64'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_mem_q", 64'(exp_mw_q.size()), 64'd0);
    do_req(1'b0, 3'b011, 64'd16, 64'd0, 1'b1, 64'hDEAD_BEEF_0123_4567);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] a;
      logic [63:0] wd;
      a  = 64'($urandom_range(0, 127));
      wd = {$urandom(), $urandom()};
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, wd, 1'b0, 64'd0);
    end
    for (int i = 0; i < 16; i++) check_eq("mem_final", mem[i], model[i]);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
